mod_exp: RTL and testbench

//  RSA modular exponentiation engine; sits directly downstream of key generation.

---
 rtl/mod_exp.sv | 94 +++++++++
 tb/tb_mod_exp.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mod_exp.sv
// mod_exp: left-to-right square-and-multiply modular exponentiation with a bit-serial interleaved modmul
module mod_exp #(
  parameter int WIDTH = 8,
  parameter bit CONST_TIME = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   base,
  input  logic [2*WIDTH-1:0]   exp,
  input  logic [2*WIDTH-1:0]   n,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 finish,
  output logic                 err
);
  localparam int OW = 2 * WIDTH;
  localparam int IW = $clog2(OW);
  typedef enum logic [2:0] {IDLE, LOAD, REDUCE, SQR, MUL, DONE} state_t;
  state_t state, nxt;
  logic [OW-1:0] br, er, nr, r, b, acc, mm_x, mm_y, red;
  logic [IW-1:0] i, j;
  logic [OW+1:0] t, red_w, n1, n2;
  logic last, mul_go;
  // REDUCE feeds base through the multiplier bits (x=1, y=base) so an
  // unreduced base is folded mod n by the same Horner-style datapath
  always_comb begin
    mm_x = (state == REDUCE) ? OW'(1) : r;
    mm_y = (state == REDUCE) ? br : (state == SQR) ? r : b;
    n1 = {2'b0, nr};
    n2 = {1'b0, nr, 1'b0};
    t = {1'b0, acc, 1'b0} + (mm_y[j] ? {2'b0, mm_x} : '0);
    red_w = (t >= n2) ? t - n2 : (t >= n1) ? t - n1 : t;
    red = red_w[OW-1:0];
    last = (j == '0);
    mul_go = er[i] || CONST_TIME;
    busy = (state != IDLE) && (state != DONE);
    finish = (state == DONE);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = (nr == '0) ? DONE : REDUCE;
      REDUCE:  nxt = last ? SQR : REDUCE;
      SQR:     nxt = !last ? SQR : mul_go ? MUL : (i == '0) ? DONE : SQR;
      MUL:     nxt = !last ? MUL : (i == '0) ? DONE : SQR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      result <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          br <= base;
          er <= exp;
          nr <= n;
          err <= 1'b0;
        end
        LOAD: begin
          r <= (nr == OW'(1)) ? '0 : OW'(1);
          i <= IW'(OW - 1);
          j <= IW'(OW - 1);
          acc <= '0;
          if (nr == '0) begin
            result <= '0;
            err <= 1'b1;
          end
        end
        REDUCE, SQR, MUL: begin
          acc <= last ? '0 : red;
          j <= last ? IW'(OW - 1) : j - 1'b1;
          if (last && state == REDUCE) b <= red;
          if (last && state == SQR) begin
            r <= red;
            if (!mul_go) i <= i - 1'b1;
            if (!mul_go && i == '0) result <= red;
          end
          if (last && state == MUL) begin
            if (er[i]) r <= red;
            i <= i - 1'b1;
            if (i == '0) result <= er[i] ? red : r;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_exp.sv
// tb_mod_exp: runs both CONST_TIME variants side by side against a plain-arithmetic modexp/latency model
module tb_mod_exp;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] base = '0, exp = '0, n = '0;
  logic [15:0] res [2];
  logic fin [2], bsy [2], ers [2];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  mod_exp #(.WIDTH(8), .CONST_TIME(1'b0)) u0 (.clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .n(n),
    .result(res[0]), .busy(bsy[0]), .finish(fin[0]), .err(ers[0]));
  mod_exp #(.WIDTH(8), .CONST_TIME(1'b1)) u1 (.clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .n(n),
    .result(res[1]), .busy(bsy[1]), .finish(fin[1]), .err(ers[1]));
  function automatic void chk(string nm, longint a, longint e);
    total++;
    if (a != e) $display("FAIL %s: got %0d expected %0d", nm, a, e);
    else passed++;
  endfunction
  function automatic longint modexp(longint bb, longint ee, longint nn);
    longint rr, x;
    if (nn == 0) return 0;
    rr = 1 % nn;
    x = bb % nn;
    for (int k = 15; k >= 0; k--) begin
      rr = (rr * rr) % nn;
      if (((ee >> k) & 1) == 1) rr = (rr * x) % nn;
    end
    return rr;
  endfunction
  function automatic longint lat(int ct, longint ee, longint nn);
    if (nn == 0) return 2;
    return ct ? 2 + 16 + 2 * 256 : 2 + 16 + 256 + 16 * $countones(ee[15:0]);
  endfunction
  task automatic run(input logic [15:0] b_v, e_v, n_v, input longint r_lit, l0_lit, l1_lit, input bit extra);
    longint r_exp, le [2];
    bit done [2], post [2];
    r_exp = (r_lit >= 0) ? r_lit : modexp(b_v, e_v, n_v);
    le[0] = (l0_lit >= 0) ? l0_lit : lat(0, e_v, n_v);
    le[1] = (l1_lit >= 0) ? l1_lit : lat(1, e_v, n_v);
    done = '{0, 0};
    post = '{0, 0};
    @(negedge clk);
    base = b_v; exp = e_v; n = n_v; start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 700 && !(post[0] && post[1]); c++) begin
      if (c == 1) begin
        start = 1'b0;
        base = 16'($urandom); exp = 16'($urandom); n = 16'($urandom);
      end
      for (int d = 0; d < 2; d++) begin
        if (c == 1 && n_v != 0) chk($sformatf("err_cleared%0d", d), ers[d], 0);
        if (done[d] && !post[d]) begin
          chk($sformatf("pulse_end%0d", d), fin[d], 0);
          chk($sformatf("idle_busy%0d", d), bsy[d], 0);
          post[d] = 1;
        end else if (!done[d]) begin
          if (fin[d]) begin
            done[d] = 1;
            chk($sformatf("result%0d b=%0d e=%0d n=%0d", d, b_v, e_v, n_v), res[d], r_exp);
            chk($sformatf("latency%0d e=%0d", d, e_v), c, le[d]);
            chk($sformatf("err%0d", d), ers[d], n_v == 0);
            chk($sformatf("busy_at_finish%0d", d), bsy[d], 0);
          end else chk($sformatf("busy%0d c=%0d", d, c), bsy[d], 1);
        end
      end
      if (extra && c == 10) begin
        start = 1'b1; base = 16'd9; exp = 16'd9; n = 16'd0;
      end
      if (extra && c == 11) start = 1'b0;
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) chk($sformatf("timeout%0d", d), post[d], 1);
  endtask
  initial begin
    int pulses [2];
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_result%0d", d), res[d], 0);
      chk($sformatf("rst_busy%0d", d), bsy[d], 0);
      chk($sformatf("rst_finish%0d", d), fin[d], 0);
      chk($sformatf("rst_err%0d", d), ers[d], 0);
    end
    rst = 1'b0;
    chk("pin_enc", modexp(65, 17, 3233), 2790);
    chk("pin_dec", modexp(2790, 2753, 3233), 65);
    chk("pin_big_base", modexp(3300, 1, 3233), 67);
    chk("pin_lat_enc", lat(0, 17, 3233), 306);
    chk("pin_lat_dec", lat(0, 2753, 3233), 354);
    chk("pin_lat_ct", lat(1, 17, 3233), 530);
    run(16'd65, 16'd17, 16'd3233, 2790, 306, 530, 0);
    run(16'd2790, 16'd2753, 16'd3233, 65, 354, 530, 1);
    run(16'd123, 16'd0, 16'd3233, 1, 274, 530, 0);
    run(16'd7, 16'hFFFF, 16'd3233, -1, 530, 530, 0);
    run(16'd3300, 16'd1, 16'd3233, 67, 290, 530, 0);
    run(16'd0, 16'd5, 16'd3233, 0, -1, 530, 0);
    run(16'd5, 16'd3, 16'd1, 0, -1, 530, 0);
    run(16'd7, 16'd3, 16'd0, 0, 2, 2, 0);
    run(16'd65, 16'd17, 16'd3233, 2790, 306, 530, 0);
    @(negedge clk);
    base = 16'd65; exp = 16'hFFFF; n = 16'd3233; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (98) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst_busy%0d", d), bsy[d], 0);
      chk($sformatf("midrst_finish%0d", d), fin[d], 0);
      chk($sformatf("midrst_result%0d", d), res[d], 0);
    end
    rst = 1'b0;
    pulses = '{0, 0};
    repeat (600) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) pulses[d] += fin[d];
    end
    for (int d = 0; d < 2; d++) chk($sformatf("no_finish_after_rst%0d", d), pulses[d], 0);
    run(16'd2790, 16'd2753, 16'd3233, 65, 354, 530, 0);
    for (int k = 0; k < 8; k++)
      run(16'($urandom), 16'($urandom), 16'($urandom_range(65535, 2)), -1, -1, -1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
